// File: rtl/up_dn_cnt_decoder.sv
// up_dn_cnt_decoder: passive decoder that recovers count direction from a sampled up/down counter bus
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   en        sample enable; cnt is sampled on edges where en=1
//   cnt       count value from the counter
//   dir       last recovered direction (1=up, 0=down)
//   step_vld  one-cycle pulse: legal step decoded
//   dir_chg   one-cycle pulse: legal step reversed the previous direction
//   wrap      one-cycle pulse: step crossed max->0 (up) or 0->max (down)
//   err       one-cycle pulse: illegal step detected
//   run_len   consecutive legal steps in the current direction, saturating
//   err_cnt   total errors since reset, saturating at all-ones
//
// Optional feature: define UDC_HOLD_ALLOW_EN to accept a zero delta (stalled counter)
// as a legal no-op sample; otherwise a zero delta counts as an error.
//
// Limitation: with WIDTH=1 an up step and a down step look the same (delta 1 both
// ways), so every step is decoded as up.
module up_dn_cnt_decoder #(
    parameter int WIDTH     = 4,
    parameter int RUN_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     cnt,
    output logic                 dir,
    output logic                 step_vld,
    output logic                 dir_chg,
    output logic                 wrap,
    output logic                 err,
    output logic [RUN_W-1:0]     run_len,
    output logic [ERR_CNT_W-1:0] err_cnt
);

`ifdef UDC_HOLD_ALLOW_EN
    localparam bit HOLD_ALLOW = 1'b1;
`else
    localparam bit HOLD_ALLOW = 1'b0;
`endif

    typedef enum logic {ACQ, TRACK} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic                 have_dir_q, have_dir_d;
    logic                 dir_q, dir_d;
    logic                 step_vld_q, step_vld_d;
    logic                 dir_chg_q, dir_chg_d;
    logic                 wrap_q, wrap_d;
    logic                 err_q, err_d;
    logic [RUN_W-1:0]     run_len_q, run_len_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]     delta;
    logic                 is_up, is_dn, is_hold, chg;

    // Modular difference; up is tested first so WIDTH=1 decodes as up.
    assign delta   = cnt - prev_q;
    assign is_up   = delta == WIDTH'(1);
    assign is_dn   = !is_up && (&delta);
    assign is_hold = HOLD_ALLOW && !(|delta);
    assign chg     = have_dir_q && (is_up != dir_q);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        have_dir_d = have_dir_q;
        dir_d      = dir_q;
        run_len_d  = run_len_q;
        err_cnt_d  = err_cnt_q;
        step_vld_d = 1'b0;
        dir_chg_d  = 1'b0;
        wrap_d     = 1'b0;
        err_d      = 1'b0;
        if (!en) begin
            state_d    = ACQ;
            have_dir_d = 1'b0;
        end else if (state_q == ACQ) begin
            state_d = TRACK;
            prev_d  = cnt;
        end else begin
            prev_d = cnt;
            if (is_up || is_dn) begin
                step_vld_d = 1'b1;
                dir_d      = is_up;
                have_dir_d = 1'b1;
                dir_chg_d  = chg;
                wrap_d     = is_up ? (&prev_q) : !(|prev_q);
                run_len_d  = (!have_dir_q || chg) ? RUN_W'(1) :
                             (&run_len_q) ? run_len_q : run_len_q + RUN_W'(1);
            end else if (!is_hold) begin
                err_d      = 1'b1;
                err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
                run_len_d  = '0;
                have_dir_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ACQ;
            prev_q     <= '0;
            have_dir_q <= 1'b0;
            dir_q      <= 1'b0;
            step_vld_q <= 1'b0;
            dir_chg_q  <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            run_len_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            have_dir_q <= have_dir_d;
            dir_q      <= dir_d;
            step_vld_q <= step_vld_d;
            dir_chg_q  <= dir_chg_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            run_len_q  <= run_len_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign dir      = dir_q;
    assign step_vld = step_vld_q;
    assign dir_chg  = dir_chg_q;
    assign wrap     = wrap_q;
    assign err      = err_q;
    assign run_len  = run_len_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_up_dn_cnt_decoder.sv
// tb_up_dn_cnt_decoder: vector table, corner sequences and random stimulus against a reference model
module tb_up_dn_cnt_decoder;
    localparam int W  = 4;
    localparam int RW = 4;
    localparam int EW = 8;
    localparam int CMAX = (1 << W) - 1;
    localparam int RMAX = (1 << RW) - 1;
    localparam int EMAX = (1 << EW) - 1;
`ifdef UDC_HOLD_ALLOW_EN
    localparam bit HA = 1'b1;
`else
    localparam bit HA = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic [W-1:0]  cnt = '0;
    logic          dir, step_vld, dir_chg, wrap, err;
    logic [RW-1:0] run_len;
    logic [EW-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    up_dn_cnt_decoder #(.WIDTH(W), .RUN_W(RW), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .en(en), .cnt(cnt),
        .dir(dir), .step_vld(step_vld), .dir_chg(dir_chg), .wrap(wrap), .err(err),
        .run_len(run_len), .err_cnt(err_cnt)
    );

    // Reference model: previous sample (-1 = none yet), direction knowledge and tallies.
    int m_prev, m_have, m_dir, m_run, m_errc, m_sv, m_dc, m_wr, m_er;

    task automatic model_reset();
        m_prev = -1; m_have = 0; m_dir = 0; m_run = 0; m_errc = 0;
        m_sv = 0; m_dc = 0; m_wr = 0; m_er = 0;
    endtask

    task automatic model_step(input bit e, input int c);
        int d;
        bit up;
        m_sv = 0; m_dc = 0; m_wr = 0; m_er = 0;
        if (!e) begin
            m_prev = -1;
            m_have = 0;
            return;
        end
        if (m_prev < 0) begin
            m_prev = c;
            return;
        end
        d = (c - m_prev + CMAX + 1) % (CMAX + 1);
        if (d == 1 || d == CMAX) begin
            up   = (d == 1);
            m_sv = 1;
            m_wr = up ? (m_prev == CMAX && c == 0) : (m_prev == 0 && c == CMAX);
            if (m_have && up != m_dir) begin
                m_dc  = 1;
                m_run = 1;
            end else if (!m_have) m_run = 1;
            else m_run = (m_run < RMAX) ? m_run + 1 : RMAX;
            m_have = 1;
            m_dir  = up;
        end else if (!(d == 0 && HA)) begin
            m_er   = 1;
            m_errc = (m_errc < EMAX) ? m_errc + 1 : EMAX;
            m_run  = 0;
            m_have = 0;
        end
        m_prev = c;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string t, input int sv, input int dc, input int wr, input int er,
                           input int d, input int rl, input int ec);
        chk({t, ".step_vld"}, 32'(step_vld), sv);
        chk({t, ".dir_chg"},  32'(dir_chg),  dc);
        chk({t, ".wrap"},     32'(wrap),     wr);
        chk({t, ".err"},      32'(err),      er);
        chk({t, ".dir"},      32'(dir),      d);
        chk({t, ".run_len"},  32'(run_len),  rl);
        chk({t, ".err_cnt"},  32'(err_cnt),  ec);
    endtask

    task automatic chk_model(input string t);
        chk_all(t, m_sv, m_dc, m_wr, m_er, m_dir, m_run, m_errc);
    endtask

    // Drives one sample away from the edge, then looks at the result 1 time unit after it.
    task automatic cyc(input bit e, input int c);
        en  = e;
        cnt = W'(c);
        @(posedge clk);
        model_step(e, c);
        #1;
    endtask

    typedef struct {
        bit e; int c;
        int sv; int dc; int wr; int er; int d; int rl; int ec;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(bit e, int c, int sv, int dc, int wr, int er, int d, int rl, int ec);
        vec_t r;
        r.e = e; r.c = c; r.sv = sv; r.dc = dc; r.wr = wr; r.er = er; r.d = d; r.rl = rl; r.ec = ec;
        return r;
    endfunction

    initial begin
        int cur;
        model_reset();
        // Directed walk through the basic scenarios, expected values written out by hand.
        tbl.push_back(v(1, 3,  0,0,0,0, 0,0,0));
        tbl.push_back(v(1, 4,  1,0,0,0, 1,1,0));
        tbl.push_back(v(1, 5,  1,0,0,0, 1,2,0));
        tbl.push_back(v(1, 6,  1,0,0,0, 1,3,0));
        tbl.push_back(v(0, 0,  0,0,0,0, 1,3,0));
        tbl.push_back(v(1, 14, 0,0,0,0, 1,3,0));
        tbl.push_back(v(1, 15, 1,0,0,0, 1,1,0));
        tbl.push_back(v(1, 0,  1,0,1,0, 1,2,0));
        tbl.push_back(v(1, 1,  1,0,0,0, 1,3,0));
        tbl.push_back(v(1, 0,  1,1,0,0, 0,1,0));
        tbl.push_back(v(1, 15, 1,0,1,0, 0,2,0));
        tbl.push_back(v(0, 0,  0,0,0,0, 0,2,0));
        tbl.push_back(v(1, 5,  0,0,0,0, 0,2,0));
        tbl.push_back(v(1, 6,  1,0,0,0, 1,1,0));
        tbl.push_back(v(1, 9,  0,0,0,1, 1,0,1));
        tbl.push_back(v(1, 10, 1,0,0,0, 1,1,1));
        tbl.push_back(v(0, 0,  0,0,0,0, 1,1,1));
        tbl.push_back(v(1, 7,  0,0,0,0, 1,1,1));
        tbl.push_back(v(1, 8,  1,0,0,0, 1,1,1));
        tbl.push_back(v(1, 8,  0,0,0,HA ? 0 : 1, 1,HA ? 1 : 0,HA ? 1 : 2));
        tbl.push_back(v(1, 9,  1,0,0,0, 1,HA ? 2 : 1,HA ? 1 : 2));

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0,0,0,0, 0,0,0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].e, tbl[i].c);
            chk_all($sformatf("vec%0d", i), tbl[i].sv, tbl[i].dc, tbl[i].wr, tbl[i].er,
                    tbl[i].d, tbl[i].rl, tbl[i].ec);
        end
        cur = 9;

        // Run-length saturation.
        for (int i = 0; i < 300; i++) begin
            cur = (cur + 1) % (CMAX + 1);
            cyc(1, cur);
            chk_model($sformatf("sat_up%0d", i));
        end
        chk("run_len_sat", 32'(run_len), RMAX);

        // Error-count saturation with repeated +2 jumps.
        for (int i = 0; i < 300; i++) begin
            cur = (cur + 2) % (CMAX + 1);
            cyc(1, cur);
            chk_model($sformatf("sat_err%0d", i));
        end
        chk("err_cnt_sat", 32'(err_cnt), EMAX);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            cur = (cur + 1) % (CMAX + 1);
            cyc(1, cur);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst", 0,0,0,0, 0,0,0);
        #2 rst = 1'b1;
        cyc(1, 5);
        chk_all("post_rst_acq", 0,0,0,0, 0,0,0);
        cyc(1, 6);
        chk_all("post_rst_step", 1,0,0,0, 1,1,0);
        cyc(1, 7);
        chk_model("post_rst_step2");

        // Two disabled cycles, then a jump that must only re-acquire.
        cyc(0, 0);
        chk_model("en_off0");
        cyc(0, 3);
        chk_model("en_off1");
        cyc(1, 12);
        chk_all("reacq", 0,0,0,0, 1,2,0);
        cyc(1, 13);
        chk_all("reacq_step", 1,0,0,0, 1,1,0);
        cur = 13;

        // Random mix of up, down, hold, jumps and disables.
        for (int i = 0; i < 600; i++) begin
            bit e;
            int r;
            e = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 9);
            if (r < 4) cur = (cur + 1) % (CMAX + 1);
            else if (r < 8) cur = (cur + CMAX) % (CMAX + 1);
            else if (r == 9) cur = $urandom_range(0, CMAX);
            cyc(e, cur);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
